// File: rtl/joy_sega_scanner.sv
// Serial joystick chain sequencer: drives two cascaded 74HC165s and the shared Sega
// select line, walks the 8-phase 3/6-button protocol and publishes active-low button words.
module joy_sega_scanner #(
    parameter int CLK_DIV      = 50,
    parameter int SETTLE_TICKS = 4,
    parameter int IDLE_TICKS   = 2000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        joy_data,
    output logic        joy_clk,
    output logic        joy_load_n,
    output logic        joy_sel,
    output logic [11:0] player1,
    output logic [11:0] player2,
    output logic [1:0]  pad_present,
    output logic [1:0]  six_btn,
    output logic        frame_done
);

    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_MAX = (IDLE_TICKS > SETTLE_TICKS) ? IDLE_TICKS : SETTLE_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [1:0] ST_SETTLE = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_SHIFT  = 2'd2;
    localparam logic [1:0] ST_IDLE   = 2'd3;

    // Shadow layout: {six, present, buttons[11:0]}
    localparam logic [13:0] SHADOW_RST = 14'h0FFF;

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_s;
    logic [1:0]       state_q, state_d;
    logic [2:0]       phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [15:0]      data_q, data_d;
    logic             sync1_q, sync2_q;
    logic             joy_clk_q, joy_clk_d;
    logic             load_n_q, load_n_d;
    logic             sel_q, sel_d;
    logic [13:0]      sh1_q, sh1_d;
    logic [13:0]      sh2_q, sh2_d;
    logic [11:0]      player1_q, player1_d;
    logic [11:0]      player2_q, player2_d;
    logic [1:0]       present_q, present_d;
    logic [1:0]       six_q, six_d;
    logic             done_q, done_d;

    // Fold one port's byte into its shadow according to the protocol phase.
    function automatic logic [13:0] capture(input logic [13:0] sh,
                                            input logic [2:0]  p,
                                            input logic [7:0]  b);
        logic [13:0] r;
        r = sh;
        case (p)
            3'd0: begin
                r[3] = b[0];
                r[2] = b[1];
                r[1] = b[2];
                r[0] = b[3];
                r[4] = b[4];
                r[5] = b[5];
            end
            3'd1: begin
                r[12] = ~b[2] & ~b[3];
                r[6]  = b[4] | ~r[12];
                r[7]  = b[5] | ~r[12];
            end
            3'd5: r[13] = r[12] & (b[3:0] == 4'b0000);
            3'd6: begin
                if (r[13]) begin
                    r[11:8] = b[3:0];
                end else begin
                    r[11:8] = 4'hF;
                end
            end
            default: r = sh;
        endcase
        return r;
    endfunction

    assign tick_s = (div_q == DIV_W'(CLK_DIV - 1));

    // Next-state logic: every protocol step is gated by the tick.
    always_comb begin
        div_d     = tick_s ? '0 : div_q + DIV_W'(1);
        state_d   = state_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        data_d    = data_q;
        joy_clk_d = joy_clk_q;
        load_n_d  = load_n_q;
        sel_d     = sel_q;
        sh1_d     = sh1_q;
        sh2_d     = sh2_q;
        player1_d = player1_q;
        player2_d = player2_q;
        present_d = present_q;
        six_d     = six_q;
        done_d    = 1'b0;
        if (tick_s) begin
            case (state_q)
                ST_SETTLE: begin
                    if (cnt_q == CNT_W'(SETTLE_TICKS - 1)) begin
                        state_d  = ST_LOAD;
                        cnt_d    = '0;
                        load_n_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_LOAD: begin
                    state_d   = ST_SHIFT;
                    load_n_d  = 1'b1;
                    joy_clk_d = 1'b0;
                    bit_d     = 4'd0;
                end
                ST_SHIFT: begin
                    if (!joy_clk_q) begin
                        data_d[bit_q] = sync2_q;
                        joy_clk_d     = 1'b1;
                    end else begin
                        joy_clk_d = 1'b0;
                        if (bit_q == 4'd15) begin
                            sh1_d = capture(sh1_q, phase_q, data_q[7:0]);
                            sh2_d = capture(sh2_q, phase_q, data_q[15:8]);
                            cnt_d = '0;
                            if (phase_q == 3'd7) begin
                                state_d   = ST_IDLE;
                                sel_d     = 1'b1;
                                player1_d = sh1_d[11:0];
                                player2_d = sh2_d[11:0];
                                present_d = {sh2_d[12], sh1_d[12]};
                                six_d     = {sh2_d[13], sh1_d[13]};
                                done_d    = 1'b1;
                            end else begin
                                state_d = ST_SETTLE;
                                phase_d = phase_q + 3'd1;
                                // Odd phases drive select low; next phase is odd iff this one is even.
                                sel_d   = phase_q[0];
                            end
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end
                end
                ST_IDLE: begin
                    if (cnt_q == CNT_W'(IDLE_TICKS - 1)) begin
                        if (enable) begin
                            state_d = ST_SETTLE;
                            phase_d = 3'd0;
                            cnt_d   = '0;
                            sel_d   = 1'b1;
                            sh1_d   = SHADOW_RST;
                            sh2_d   = SHADOW_RST;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State registers with synchronous active-low reset; joy_data gets a 2-FF synchroniser.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_q     <= '0;
            state_q   <= ST_SETTLE;
            phase_q   <= 3'd0;
            cnt_q     <= '0;
            bit_q     <= 4'd0;
            data_q    <= 16'hFFFF;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            joy_clk_q <= 1'b0;
            load_n_q  <= 1'b1;
            sel_q     <= 1'b1;
            sh1_q     <= SHADOW_RST;
            sh2_q     <= SHADOW_RST;
            player1_q <= 12'hFFF;
            player2_q <= 12'hFFF;
            present_q <= 2'b00;
            six_q     <= 2'b00;
            done_q    <= 1'b0;
        end else begin
            div_q     <= div_d;
            state_q   <= state_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            data_q    <= data_d;
            sync1_q   <= joy_data;
            sync2_q   <= sync1_q;
            joy_clk_q <= joy_clk_d;
            load_n_q  <= load_n_d;
            sel_q     <= sel_d;
            sh1_q     <= sh1_d;
            sh2_q     <= sh2_d;
            player1_q <= player1_d;
            player2_q <= player2_d;
            present_q <= present_d;
            six_q     <= six_d;
            done_q    <= done_d;
        end
    end

    assign joy_clk     = joy_clk_q;
    assign joy_load_n  = load_n_q;
    assign joy_sel     = sel_q;
    assign player1     = player1_q;
    assign player2     = player2_q;
    assign pad_present = present_q;
    assign six_btn     = six_q;
    assign frame_done  = done_q;

endmodule

// File: tb/tb_joy_sega_scanner.sv
// Bench for joy_sega_scanner: models the 165 chain plus Sega 3/6-button pads and
// compares the decoded words against the buttons each pad is holding.
module tb_joy_sega_scanner;

    localparam int CLK_DIV = 4;
    localparam int SETTLE  = 4;
    localparam int IDLE    = 200;
    localparam int FIRST   = 8 * (SETTLE + 1 + 32) * CLK_DIV;
    localparam int FRAME   = (8 * (SETTLE + 1 + 32) + IDLE) * CLK_DIV;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        joy_data;
    logic        joy_clk, joy_load_n, joy_sel, frame_done;
    logic [11:0] player1, player2;
    logic [1:0]  pad_present, six_btn;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Pad descriptions: type 0 = none, 1 = 3-button, 2 = 6-button; buttons active low.
    int          ptype [2];
    logic [11:0] pbtn [2];

    joy_sega_scanner #(.CLK_DIV(CLK_DIV), .SETTLE_TICKS(SETTLE), .IDLE_TICKS(IDLE)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .joy_data(joy_data),
        .joy_clk(joy_clk), .joy_load_n(joy_load_n), .joy_sel(joy_sel),
        .player1(player1), .player2(player2), .pad_present(pad_present),
        .six_btn(six_btn), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // What a pad drives on its six lines given the select level and edges since timeout.
    function automatic logic [7:0] pad_byte(input int t, input logic [11:0] b, input int e, input logic sel);
        if (t == 0) return 8'hFF;
        if (t == 2 && e == 5) return {2'b11, b[7], b[6], 4'b0000};
        if (t == 2 && e == 6) return {2'b11, b[5], b[4], b[11], b[10], b[9], b[8]};
        if (t == 2 && e == 7) return {2'b11, b[7], b[6], 4'b1111};
        if (sel) return {2'b11, b[5], b[4], b[0], b[1], b[2], b[3]};
        return {2'b11, b[7], b[6], 2'b00, b[2], b[3]};
    endfunction

    // Decoded result a pad should produce: {six, present, buttons}.
    function automatic logic [13:0] pad_expect(input int t, input logic [11:0] b);
        if (t == 1) return {1'b0, 1'b1, 4'hF, b[7:0]};
        if (t == 2) return {1'b1, 1'b1, b};
        return {2'b00, 12'hFFF};
    endfunction

    int          e_cnt = 0;
    int          quiet = 0;
    logic        sel_prev = 1'b1;
    logic        jclk_prev = 1'b0;
    logic [15:0] chain = 16'hFFFF;

    // Pad select-edge counter with a timeout, and the cascaded 165 pair.
    always @(posedge clk) begin
        sel_prev  <= joy_sel;
        jclk_prev <= joy_clk;
        if (joy_sel !== sel_prev) begin
            e_cnt <= e_cnt + 1;
            quiet <= 0;
        end else if (quiet > 400) begin
            e_cnt <= 0;
        end else begin
            quiet <= quiet + 1;
        end
        if (!joy_load_n)
            chain <= {pad_byte(ptype[1], pbtn[1], e_cnt, joy_sel), pad_byte(ptype[0], pbtn[0], e_cnt, joy_sel)};
        else if (joy_clk && !jclk_prev)
            chain <= {1'b1, chain[15:1]};
    end

    assign joy_data = chain[0];

    logic        mon_en = 1'b0;
    int          glitches = 0;
    logic [11:0] p1_prev = 12'hFFF;
    logic [11:0] p2_prev = 12'hFFF;
    logic [3:0]  fl_prev = 4'h0;

    always @(negedge clk) begin
        if (mon_en && !frame_done &&
            (player1 !== p1_prev || player2 !== p2_prev || {six_btn, pad_present} !== fl_prev))
            glitches <= glitches + 1;
        p1_prev <= player1;
        p2_prev <= player2;
        fl_prev <= {six_btn, pad_present};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // which: 0 frame_done, 1 joy_load_n, 2 joy_sel, 3 joy_clk
    task automatic wait_for(input int which, input logic lvl, input int budget, output int at);
        logic hit;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            case (which)
                0: hit = frame_done;
                1: hit = joy_load_n;
                2: hit = joy_sel;
                default: hit = joy_clk;
            endcase
            if (hit == lvl) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk($sformatf("timeout_w%0d", which), 32'd0, 32'd1);
    endtask

    task automatic check_outputs(input string tag);
        logic [13:0] e1, e2;
        e1 = pad_expect(ptype[0], pbtn[0]);
        e2 = pad_expect(ptype[1], pbtn[1]);
        chk($sformatf("%s_p1", tag), 32'(player1), 32'(e1[11:0]));
        chk($sformatf("%s_p2", tag), 32'(player2), 32'(e2[11:0]));
        chk($sformatf("%s_present", tag), 32'(pad_present), 32'({e2[12], e1[12]}));
        chk($sformatf("%s_six", tag), 32'(six_btn), 32'({e2[13], e1[13]}));
    endtask

    task automatic check_reset(input string tag);
        chk($sformatf("%s_p1", tag), 32'(player1), 32'h0FFF);
        chk($sformatf("%s_p2", tag), 32'(player2), 32'h0FFF);
        chk($sformatf("%s_flags", tag), 32'({six_btn, pad_present}), 32'h0);
        chk($sformatf("%s_pins", tag), 32'({joy_sel, joy_load_n, joy_clk, frame_done}), 32'hC);
    endtask

    task automatic rand_pads();
        for (int k = 0; k < 2; k++) begin
            ptype[k] = int'($urandom_range(0, 2));
            pbtn[k]  = 12'($urandom);
            // A 3-button pad cannot hold Up and Down together.
            if (ptype[k] == 1 && pbtn[k][3:2] == 2'b00) pbtn[k][2] = 1'b1;
        end
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: got=running want=finished");
        $fatal(1);
    end

    initial begin
        int at, c0, last, dones, loads;
        ptype[0] = 0; ptype[1] = 0;
        pbtn[0] = 12'hFFF; pbtn[1] = 12'hFFF;

        // 1: reset values, first load timing, first frame with no pads
        enable  = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("rst");
        reset_n = 1'b1;
        c0 = cyc;
        wait_for(1, 1'b0, FRAME, at);
        chk("first_load", 32'(at - c0), 32'(SETTLE * CLK_DIV));
        wait_for(0, 1'b1, 2 * FRAME, at);
        chk("first_done", 32'(at - c0), 32'(FIRST));
        check_outputs("empty");
        last = at;

        // 2: 3-button pad on port 1 holding Up+A
        ptype[0] = 1; pbtn[0] = 12'hFB7;
        wait_for(0, 1'b1, 2 * FRAME, at);
        chk("t2_spacing", 32'(at - last), 32'(FRAME));
        last = at;
        chk("t2_p1", 32'(player1), 32'h0FB7);
        chk("t2_p2", 32'(player2), 32'h0FFF);
        chk("t2_present", 32'(pad_present), 32'h1);
        chk("t2_six", 32'(six_btn), 32'h0);

        // 3: 6-button pad on port 2 holding Right+X+Mode, two identical frames
        ptype[1] = 2; pbtn[1] = 12'h3FE;
        wait_for(0, 1'b1, 2 * FRAME, at);
        last = at;
        chk("t3_p2", 32'(player2), 32'h03FE);
        chk("t3_present", 32'(pad_present), 32'h3);
        chk("t3_six", 32'(six_btn), 32'h2);
        wait_for(0, 1'b1, 2 * FRAME, at);
        chk("t3_spacing", 32'(at - last), 32'(FRAME));
        last = at;
        chk("t3_p1_again", 32'(player1), 32'h0FB7);
        chk("t3_p2_again", 32'(player2), 32'h03FE);

        // 4: random pads swapped during phase 3
        mon_en = 1'b1;
        for (int it = 0; it < 6; it++) begin
            wait_for(2, 1'b0, FRAME, at);
            wait_for(2, 1'b1, FRAME, at);
            wait_for(2, 1'b0, FRAME, at);
            rand_pads();
            wait_for(0, 1'b1, 2 * FRAME, at);
            chk("t4_spacing_a", 32'(at - last), 32'(FRAME));
            last = at;
            wait_for(0, 1'b1, 2 * FRAME, at);
            chk("t4_spacing_b", 32'(at - last), 32'(FRAME));
            last = at;
            check_outputs($sformatf("t4_%0d", it));
        end
        mon_en = 1'b0;
        chk("t4_no_early_change", 32'(glitches), 32'd0);

        // 5: drop enable in phase 2, then resume
        wait_for(2, 1'b0, FRAME, at);
        wait_for(2, 1'b1, FRAME, at);
        enable = 1'b0;
        dones = 0;
        loads = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (dones > 0 && !joy_load_n) loads++;
            if (frame_done) dones++;
        end
        chk("t5_one_done", 32'(dones), 32'd1);
        chk("t5_no_load", 32'(loads), 32'd0);
        chk("t5_sel_idle", 32'(joy_sel), 32'd1);
        check_outputs("t5_hold");
        enable = 1'b1;
        c0 = cyc;
        wait_for(1, 1'b0, FRAME, at);
        chk("t5_resume_load", 32'(at >= 0 && (at - c0) <= (SETTLE + 1) * CLK_DIV), 32'd1);
        wait_for(2, 1'b0, FRAME, at);
        chk("t5_resume_sel", 32'(at >= 0 && (at - c0) <= (SETTLE + 1 + 32 + 1) * CLK_DIV), 32'd1);
        wait_for(0, 1'b1, 2 * FRAME, at);
        check_outputs("t5_new");

        // 6: one-cycle reset in the middle of phase 4 shifting
        ptype[0] = 1; pbtn[0] = 12'($urandom) | 12'h004;
        ptype[1] = 1; pbtn[1] = 12'($urandom) | 12'h008;
        wait_for(2, 1'b0, FRAME, at);
        wait_for(2, 1'b1, FRAME, at);
        wait_for(2, 1'b0, FRAME, at);
        wait_for(2, 1'b1, FRAME, at);
        wait_for(3, 1'b1, FRAME, at);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check_reset("t6_rst");
        reset_n = 1'b1;
        c0 = cyc;
        wait_for(0, 1'b1, 2 * FRAME, at);
        chk("t6_done", 32'(at - c0), 32'(FIRST));
        check_outputs("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
